seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
// - Output-side counterpart to the button debouncer: it drives the user-facing 4-digit,
//   common-anode seven-segment display of the calculator.
// - Latches a 16-bit hex value on a load strobe and holds it in a staging register.
// - Commits staged data only at a frame boundary, so a frame never shows a mix of old and
//   new digits (no tearing).
// - Time-multiplexes the anodes, with optional leading-zero blanking.
// PARAMETERS
// - DIGIT_TICKS  10000  TEN_MHZ_CLK cycles each digit is lit (1 ms at 10 MHz); minimum 1.
// PORTS
// - TEN_MHZ_CLK  in   1   system clock; all state changes on its rising edge.
// - reset_n      in   1   asynchronous, active-low reset.
// - value        in   16  hex digits; [3:0] = digit0 (rightmost), [15:12] = digit3.
// - dp           in   4   decimal point request per digit; 1 = lit; bit i belongs to digit i.
// - blank_lz     in   1   1 = suppress leading zeros; sampled with load.
// - load         in   1   1-cycle strobe; samples value, dp and blank_lz into staging.
// - seg          out  7   segments {g,f,e,d,c,b,a}, active-low.
// - dp_n         out  1   decimal point, active-low.
// - an           out  4   anodes, active-low; bit i = digit i.
// - pending      out  1   1 = staged data not yet committed to the display.
// - frame_done   out  1   1-cycle pulse at each frame boundary.
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately):
//   - an=4'b1111, seg=7'h7F, dp_n=1, pending=0, frame_done=0.
//   - tick=0, idx=0; staging and display registers = {value 0, dp 0, blank_lz 0}.
// - tick counter:
//   - Counts 0..DIGIT_TICKS-1, width $clog2(DIGIT_TICKS+1).
//   - At DIGIT_TICKS-1 it wraps to 0 and idx (2 bits) increments; 3 -> 0 wraps.
//   - With DIGIT_TICKS=1, idx advances every cycle.
// - Frame boundary: the cycle where tick==DIGIT_TICKS-1 and idx==3.
//   - Frame period = 4*DIGIT_TICKS cycles.
//   - frame_done=1 for exactly that cycle.
// - Load:
//   - load=1 copies value/dp/blank_lz into staging and sets pending=1.
//   - Repeated loads before a boundary: the last one wins.
// - Commit:
//   - At a boundary with pending=1, the display register takes the staging contents
//     (the pre-load contents, if load is high in that same cycle) and pending clears.
//   - Load coincident with a boundary: the previous staging is committed, the new data is
//     staged, and pending stays 1 until the next boundary.
//   - Boundary with pending=0: the display register is unchanged.
// - Outputs are registered from idx and the display register, one cycle of latency.
//   - First edge after reset release: an=4'b1110, showing digit0.
//   - Exactly one anode is low per cycle, except for blanked digits.
// - Decode, 0..F, standard hex:
//   - 0=1000000, 1=1111001, 2=0100100, 5=0010010, 8=0000000.
//   - A=0001000, F=0001110.
//   - dp_n = ~dp[idx].
// - Blanking (blank_lz=1):
//   - Digit i in 3..1 is blank when nibble i and all higher nibbles are 0.
//   - A blank digit drives an=4'b1111, seg=7'h7F and dp_n=1 for its whole slot.
//   - digit0 is never blanked.
// - Inputs are assumed synchronous to TEN_MHZ_CLK; no internal synchronisers.
// TESTING (DIGIT_TICKS=4)
// 1. Reset and idle:
//    - Hold reset_n=0 -> an=1111, seg=7F, dp_n=1, pending=0.
//    - Release reset -> an steps 1110, 1101, 1011, 0111 for 4 cycles each; seg=1000000 on
//      every digit.
//    - frame_done pulses every 16 cycles.
// 2. Load value=16'h12AF, dp=4'b0100:
//    - pending=1 until the next frame_done.
//    - Following frame shows digit0=0001110, digit1=0001000, digit2=0100100 with dp_n=0,
//      digit3=1111001.
// 3. Leading-zero blanking:
//    - blank_lz=1, value=16'h0050 -> digit3 and digit2 slots an=1111; digit1=0010010;
//      digit0=1000000.
//    - value=0 -> only digit0 lit.
// 4. Load coincident with a boundary:
//    - Stage 16'h1111, then load 16'h2222 in the frame_done cycle.
//    - Next frame shows 1111 with pending=1; the frame after shows 2222 with pending=0.
// 5. Back-to-back loads:
//    - Load 16'hAAAA, then 16'h5555 two cycles later, both inside one frame.
//    - Next frame shows 5555.
// 6. Reset mid-frame:
//    - Assert reset_n=0 while pending=1 in idx=2 -> outputs go to reset values without
//      waiting for a clock edge.
//    - After release, digit0 shows 0 and pending=0.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode hex display scanner with tear-free frame commit
// Ports:
//   TEN_MHZ_CLK  in   1   system clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   value        in   16  hex digits, [3:0] = digit0 (rightmost)
//   dp           in   4   decimal point request per digit, 1 = lit
//   blank_lz     in   1   suppress leading zeros, sampled with load
//   load         in   1   1-cycle strobe staging value/dp/blank_lz
//   seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp_n         out  1   decimal point, active-low
//   an           out  4   anodes, active-low, bit i = digit i
//   pending      out  1   staged data not yet shown
//   frame_done   out  1   1-cycle pulse in the last cycle of each frame
module seven_seg_scan #(
  parameter int DIGIT_TICKS = 10000
) (
  input  logic        TEN_MHZ_CLK,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);
  localparam int TW = $clog2(DIGIT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  logic [TW-1:0] r_tick;
  logic [1:0]    r_idx;
  logic [15:0]   r_stg_val, r_dsp_val;
  logic [3:0]    r_stg_dp, r_dsp_dp;
  logic          r_stg_blz, r_dsp_blz, r_pending;
  logic [6:0]    r_seg;
  logic          r_dp_n;
  logic [3:0]    r_an;
  logic          w_tick_last, w_boundary, w_blank;
  logic [15:0]   w_upper;
  logic [6:0]    w_seg;
  assign w_tick_last = r_tick == TICK_LAST;
  assign w_boundary  = w_tick_last && r_idx == 2'd3;
  // Display value with the current digit shifted down to [3:0]; zero means this
  // digit and every digit to its left are zero, i.e. a leading zero.
  assign w_upper     = r_dsp_val >> {r_idx, 2'b00};
  assign w_blank     = r_dsp_blz && r_idx != 2'd0 && w_upper == 16'h0;
  assign seg         = r_seg;
  assign dp_n        = r_dp_n;
  assign an          = r_an;
  assign pending     = r_pending;
  assign frame_done  = w_boundary;
  always_comb begin
    w_seg = 7'h7F;
    case (w_upper[3:0])
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'h7F;
    endcase
  end
  always_ff @(posedge TEN_MHZ_CLK or negedge reset_n)
    if (!reset_n) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else begin
      r_tick <= w_tick_last ? '0 : r_tick + TW'(1);
      if (w_tick_last) r_idx <= r_idx + 2'd1;
    end
  // The display register reads the old staging contents, so a load in the
  // boundary cycle commits the previous data and keeps the new data pending.
  always_ff @(posedge TEN_MHZ_CLK or negedge reset_n)
    if (!reset_n) begin
      r_stg_val <= '0;
      r_stg_dp  <= '0;
      r_stg_blz <= 1'b0;
      r_dsp_val <= '0;
      r_dsp_dp  <= '0;
      r_dsp_blz <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_stg_val <= value;
        r_stg_dp  <= dp;
        r_stg_blz <= blank_lz;
      end
      if (w_boundary && r_pending) begin
        r_dsp_val <= r_stg_val;
        r_dsp_dp  <= r_stg_dp;
        r_dsp_blz <= r_stg_blz;
      end
      r_pending <= load ? 1'b1 : (w_boundary ? 1'b0 : r_pending);
    end
  always_ff @(posedge TEN_MHZ_CLK or negedge reset_n)
    if (!reset_n) begin
      r_an   <= 4'hF;
      r_seg  <= 7'h7F;
      r_dp_n <= 1'b1;
    end else begin
      r_an   <= w_blank ? 4'hF : ~(4'b0001 << r_idx);
      r_seg  <= w_blank ? 7'h7F : w_seg;
      r_dp_n <= w_blank | ~r_dsp_dp[r_idx];
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for the seven-segment scanner
module tb_seven_seg_scan;
  localparam int DT = 4;
  localparam int FR = 4 * DT;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       pending;
    logic       frame_done;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        m_out;
  logic [6:0]  hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] m_stg_v, m_dsp_v;
  logic [3:0]  m_stg_d, m_dsp_d;
  logic        m_stg_b, m_dsp_b, m_pend;
  int          m_cyc;
  logic [3:0][6:0] g_seg;
  logic [3:0][3:0] g_an;
  logic [3:0]      g_dpn;
  logic            g_pend;
  seven_seg_scan #(.DIGIT_TICKS(DT)) dut (
    .TEN_MHZ_CLK(clk),
    .reset_n(reset_n),
    .value(value),
    .dp(dp),
    .blank_lz(blank_lz),
    .load(load),
    .seg(seg),
    .dp_n(dp_n),
    .an(an),
    .pending(pending),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_stg_v = '0; m_stg_d = '0; m_stg_b = 1'b0;
    m_dsp_v = '0; m_dsp_d = '0; m_dsp_b = 1'b0;
    m_pend = 1'b0;
    m_cyc = 0;
    sb.delete();
  endtask
  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic blz);
    int pos, dig;
    logic [15:0] up;
    logic bl;
    exp_t e;
    load = ld; value = v; dp = d; blank_lz = blz;
    @(posedge clk);
    pos = m_cyc % FR;
    dig = pos / DT;
    up = m_dsp_v >> (4 * dig);
    bl = m_dsp_b && dig != 0 && up == 16'h0;
    e.an = bl ? 4'hF : ~(4'b0001 << dig);
    e.seg = bl ? 7'h7F : hex7[up[3:0]];
    e.dp_n = bl ? 1'b1 : ~m_dsp_d[dig];
    if (pos == FR - 1) begin
      if (m_pend) begin
        m_dsp_v = m_stg_v; m_dsp_d = m_stg_d; m_dsp_b = m_stg_b;
      end
      m_pend = 1'b0;
    end
    if (ld) begin
      m_stg_v = v; m_stg_d = d; m_stg_b = blz; m_pend = 1'b1;
    end
    m_cyc++;
    e.pending = m_pend;
    e.frame_done = (m_cyc % FR) == FR - 1;
    sb.push_back(e);
    #1 load = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 16'h0, 4'h0, 1'b0);
  endtask
  task automatic to_boundary();
    int n = 0;
    while (frame_done !== 1'b1 && n < 2 * FR) begin
      idle(1);
      n++;
    end
    check("frame_done_reached", frame_done, 1'b1);
  endtask
  // Starts in a frame_done cycle; samples each digit of the following frame
  // and ends in the next frame_done cycle.
  task automatic grab_frame(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic blz);
    for (int j = 1; j <= FR; j++) begin
      if (j == 1) tick(ld, v, d, blz); else idle(1);
      if (j >= 2 && (j - 2) % DT == 0) begin
        g_seg[(j - 2) / DT] = seg;
        g_an[(j - 2) / DT]  = an;
        g_dpn[(j - 2) / DT] = dp_n;
        if (j == 2) g_pend = pending;
      end
    end
  endtask
  always @(negedge clk)
    if (reset_n && sb.size() > 0) begin
      m_out = sb.pop_front();
      check("sb_an", an, m_out.an);
      check("sb_seg", seg, m_out.seg);
      check("sb_dp_n", dp_n, m_out.dp_n);
      check("sb_pending", pending, m_out.pending);
      check("sb_frame_done", frame_done, m_out.frame_done);
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);
    to_boundary();
    grab_frame(1'b0, 16'h0, 4'h0, 1'b0);
    check("idle_segs", g_seg, {4{7'b1000000}});
    check("idle_ans", g_an, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
    check("frame_period", frame_done, 1'b1);
    idle(3);
    tick(1'b1, 16'h12AF, 4'b0100, 1'b0);
    check("load_pending", pending, 1'b1);
    to_boundary();
    check("pending_at_boundary", pending, 1'b1);
    grab_frame(1'b0, 16'h0, 4'h0, 1'b0);
    check("d0_F", g_seg[0], 7'b0001110);
    check("d1_A", g_seg[1], 7'b0001000);
    check("d2_2", g_seg[2], 7'b0100100);
    check("d3_1", g_seg[3], 7'b1111001);
    check("dp_n_12AF", g_dpn, 4'b1011);
    check("committed_pending", g_pend, 1'b0);
    idle(2);
    tick(1'b1, 16'h0050, 4'h0, 1'b1);
    to_boundary();
    grab_frame(1'b0, 16'h0, 4'h0, 1'b0);
    check("lz_an3", g_an[3], 4'hF);
    check("lz_an2", g_an[2], 4'hF);
    check("lz_seg3", g_seg[3], 7'h7F);
    check("lz_d1", g_seg[1], 7'b0010010);
    check("lz_an1", g_an[1], 4'b1101);
    check("lz_d0", g_seg[0], 7'b1000000);
    idle(2);
    tick(1'b1, 16'h0000, 4'h0, 1'b1);
    to_boundary();
    grab_frame(1'b0, 16'h0, 4'h0, 1'b0);
    check("zero_only_d0", g_an, {4'hF, 4'hF, 4'hF, 4'hE});
    idle(2);
    tick(1'b1, 16'h1111, 4'h0, 1'b0);
    to_boundary();
    grab_frame(1'b1, 16'h2222, 4'h0, 1'b0);
    check("coinc_1111", g_seg, {4{7'b1111001}});
    check("coinc_pending", g_pend, 1'b1);
    grab_frame(1'b0, 16'h0, 4'h0, 1'b0);
    check("coinc_2222", g_seg, {4{7'b0100100}});
    check("coinc_pending_clr", g_pend, 1'b0);
    idle(1);
    tick(1'b1, 16'hAAAA, 4'h0, 1'b0);
    idle(1);
    tick(1'b1, 16'h5555, 4'h0, 1'b0);
    to_boundary();
    grab_frame(1'b0, 16'h0, 4'h0, 1'b0);
    check("b2b_5555", g_seg, {4{7'b0010010}});
    idle(1);
    tick(1'b1, 16'h1234, 4'hF, 1'b0);
    for (int n = 0; n < FR && m_cyc % FR != 2 * DT + 1; n++) idle(1);
    check("mid_pending", pending, 1'b1);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp_n", dp_n, 1'b1);
    check("async_pending", pending, 1'b0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'b1000000);
    check("post_rst_dp_n", dp_n, 1'b1);
    check("post_rst_pending", pending, 1'b0);
    idle(2 * FR);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
